// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: ALU-control codes, datapath width
// and the multi-cycle multiply/divide sequencer states.
package mips_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1010;
  localparam logic [3:0] ALU_DIV = 4'b1111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers for the iterative signed multiply and restoring divide,
// plus the final sign fix that produces the HI/LO result.
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic             finish,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             b_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  logic               div_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               dz_q;
  logic [WIDTH-1:0]   mag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  assign b_zero = (op_b == '0);
  assign mag_a  = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b  = op_b[WIDTH-1] ? -op_b : op_b;

  // acc_q holds {partial product, remaining multiplier bits} for MUL and
  // {remainder, dividend bits shifting into quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, mag_q});
    div_diff  = div_shift[WIDTH-1:0] - mag_q;
    div_next  = {(div_fits ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_fits};
  end

  always_comb begin
    neg  = sign_a_q ^ sign_b_q;
    prod = neg ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (dz_q) begin
      // No iterations ran, so the low half still holds |op_a|; restore its sign.
      hi_d = sign_a_q ? -quo : quo;
      lo_d = '1;
    end else if (div_q) begin
      hi_d = sign_a_q ? -rem : rem;
      lo_d = neg ? -quo : quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      mag_q    <= '0;
      acc_q    <= '0;
    end else if (load) begin
      div_q    <= load_div;
      sign_a_q <= op_a[WIDTH-1];
      sign_b_q <= op_b[WIDTH-1];
      dz_q     <= load_div & b_zero;
      mag_q    <= load_div ? mag_b : mag_a;
      acc_q    <= {{WIDTH{1'b0}}, (load_div ? mag_a : mag_b)};
    end else if (step) begin
      acc_q    <= div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (load) begin
      dbz_q <= 1'b0;
    end else if (finish) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      dbz_q <= dz_q;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV controller: FSM, iteration counter, done handshake and the
// pipeline stall that freezes the single-cycle datapath until HI/LO are ready.
module muldiv_sequencer #(
  parameter int unsigned WIDTH   = mips_pkg::WIDTH_DEFAULT,
  parameter logic [3:0]  ALU_MUL = mips_pkg::ALU_MUL,
  parameter logic [3:0]  ALU_DIV = mips_pkg::ALU_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mips_pkg::md_state_e state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic is_md;
  logic is_div;
  logic idle;
  logic accept;
  logic b_zero;
  logic step;
  logic finish;

  assign is_div = (alu_ctl == ALU_DIV);
  assign is_md  = (alu_ctl == ALU_MUL) | is_div;
  assign idle   = (state_q == mips_pkg::StIdle);
  assign accept = idle & start & is_md & ~flush;
  assign step   = (state_q == mips_pkg::StRun) & ~flush;
  assign finish = (state_q == mips_pkg::StFinish) & ~flush;

  // Freeze from the request cycle itself so the instruction does not advance.
  assign stall = busy_q | (idle & start & is_md);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      mips_pkg::StIdle: begin
        if (accept) begin
          count_d = '0;
          busy_d  = 1'b1;
          state_d = (is_div && b_zero) ? mips_pkg::StFinish : mips_pkg::StRun;
        end
      end
      mips_pkg::StRun: begin
        if (flush) begin
          state_d = mips_pkg::StIdle;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
          if (count_q == CntLast) begin
            state_d = mips_pkg::StFinish;
          end
        end
      end
      mips_pkg::StFinish: begin
        state_d = mips_pkg::StIdle;
        busy_d  = 1'b0;
        done_d  = ~flush;
      end
      default: begin
        state_d = mips_pkg::StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= mips_pkg::StIdle;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_div   (is_div),
    .step       (step),
    .finish     (finish),
    .op_a       (op_a),
    .op_b       (op_b),
    .b_zero     (b_zero),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed MUL/DIV results, latency,
// stall behaviour, ignored starts, flush and asynchronous reset.
module tb_muldiv_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam logic [3:0] CtlMul = 4'b1010;
  localparam logic [3:0] CtlDiv = 4'b1111;
  localparam logic [3:0] CtlAdd = 4'b0010;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  int checks;
  int failures;

  muldiv_sequencer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_ctl    (alu_ctl),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input logic [3:0] ctl, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    start   = 1'b1;
    alu_ctl = ctl;
    op_a    = a;
    op_b    = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Counts edges until done is seen; gaps counts pre-done cycles with stall low.
  task automatic wait_done(input string tag, output int lat, output int gaps);
    bit got;
    got  = 1'b0;
    lat  = 0;
    gaps = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
      else if (!stall) gaps++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  int lat;
  int gaps;
  int cnt;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    alu_ctl  = 4'b0000;
    op_a     = '0;
    op_b     = '0;
    flush    = 1'b0;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MUL 7 * -3 = -21
    start = 1'b1; alu_ctl = CtlMul; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    #1;
    check("mul_stall_req", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mul_busy", 64'(busy), 64'd1);
    wait_done("mul", lat, gaps);
    check("mul_latency", 64'(lat), 64'd33);
    check("mul_stall_gaps", 64'(gaps), 64'd0);
    check("mul_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mul_lo", 64'(lo), 64'hFFFF_FFEB);
    check("mul_busy_done", 64'(busy), 64'd0);
    check("mul_stall_done", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    check("mul_done_pulse", 64'(done), 64'd0);

    // DIV -7 / 2 -> q=-3, r=-1
    issue(CtlDiv, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", lat, gaps);
    check("div_neg_latency", 64'(lat), 64'd33);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div_neg_dbz", 64'(div_by_zero), 64'd0);

    // Overflow: most-negative / -1 wraps to itself
    issue(CtlDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", lat, gaps);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'd0);

    // DIV 5 / 0: straight to FINISH, done in the second cycle after the start cycle
    issue(CtlDiv, 32'd5, 32'd0);
    wait_done("dbz", lat, gaps);
    check("dbz_latency", 64'(lat), 64'd1);
    check("dbz_hi", 64'(hi), 64'd5);
    check("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("dbz_flag", 64'(div_by_zero), 64'd1);

    // MUL 3 * 4 clears the sticky flag at acceptance
    issue(CtlMul, 32'd3, 32'd4);
    check("dbz_clear", 64'(div_by_zero), 64'd0);
    wait_done("mul34", lat, gaps);
    check("mul34_hi", 64'(hi), 64'd0);
    check("mul34_lo", 64'(lo), 64'd12);

    // Start with a non-muldiv code is ignored
    start = 1'b1; alu_ctl = CtlAdd; op_a = 32'd1; op_b = 32'd1;
    #1;
    check("add_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("add_busy", 64'(busy), 64'd0);
    count_dones(4, cnt);
    check("add_no_done", 64'(cnt), 64'd0);

    // Start pulsed while a MUL 1000*1000 is in flight has no effect
    issue(CtlMul, 32'd1000, 32'd1000);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; alu_ctl = CtlDiv; op_a = 32'd9; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_start_busy", 64'(busy), 64'd1);
    wait_done("busy_start", lat, gaps);
    check("busy_start_latency", 64'(lat), 64'd27);
    check("busy_start_hilo", {hi, lo}, 64'h0000_0000_000F_4240);
    count_dones(40, cnt);
    check("busy_start_one_done", 64'(cnt), 64'd0);

    // Flush at count=10 of MUL 0x12345678 * 0x10
    issue(CtlMul, 32'h1234_5678, 32'h10);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    count_dones(40, cnt);
    check("flush_no_done", 64'(cnt), 64'd0);
    check("flush_hilo_kept", {hi, lo}, 64'h0000_0000_000F_4240);
    issue(CtlMul, 32'd2, 32'd3);
    check("flush_next_accept", 64'(busy), 64'd1);
    wait_done("post_flush", lat, gaps);
    check("post_flush_lo", 64'(lo), 64'd6);

    // Flush in IDLE beats a simultaneous start
    start = 1'b1; alu_ctl = CtlMul; op_a = 32'd5; op_b = 32'd5; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);

    // Asynchronous reset at count=20 of DIV 100/7
    issue(CtlDiv, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_done", 64'(done), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(CtlDiv, 32'd100, 32'd7);
    wait_done("div100", lat, gaps);
    check("div100_lo", 64'(lo), 64'd14);
    check("div100_hi", 64'(hi), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for MUL (ALU code 4'b1010) and DIV (ALU code 4'b1111).
- Runs a radix-2 iterative signed multiply (shift-add) or restoring divide over WIDTH cycles and writes the HI/LO result registers.
- Drives a stall so the single-cycle datapath freezes until the result is ready.
- Sits beside the ALU, fed by the ALU-control code and the register-file operands.

Parameters:
- WIDTH, 32, operand width in bits; the HI/LO pair is 2*WIDTH.
- ALU_MUL, 4'b1010, ALU-control code that starts a multiply.
- ALU_DIV, 4'b1111, ALU-control code that starts a divide.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from the decode/ALU stage; sampled only in IDLE.
- alu_ctl  in  4  ALU-control code qualifying start.
- op_a  in  WIDTH  multiplicand / dividend (two's complement).
- op_b  in  WIDTH  multiplier / divisor (two's complement).
- flush  in  1  synchronous abort of any operation in progress.
- busy  out  1  operation in progress (registered).
- stall  out  1  combinational pipeline freeze.
- done  out  1  one-cycle pulse; hi/lo valid.
- hi  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- lo  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- div_by_zero  out  1  sticky flag for the last DIV; cleared at the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, iteration count=0.
- FSM states: IDLE, RUN, FINISH.
- Accepted start: start=1 and alu_ctl is ALU_MUL or ALU_DIV, in IDLE, with flush=0.
- IDLE:
  - On an accepted start, latch the operation, operand sign bits and |op_a|, |op_b| (unsigned WIDTH bits, so |0x80..0| = 0x80..0). Set count=0, busy=1, div_by_zero=0.
  - DIV with op_b=0 goes directly to FINISH. Everything else goes to RUN.
  - start with any other alu_ctl is ignored; busy stays 0.
- RUN: one iteration per edge; count increments. After the iteration at count=WIDTH-1, go to FINISH.
  - MUL: accumulate into a 2W-bit product, one multiplier bit per cycle.
  - DIV: shift the remainder left, trial-subtract the divisor, set the quotient bit, restore on a negative result.
- FINISH (one edge):
  - Apply the sign fix: product negated if sign_a^sign_b; quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
  - Write hi/lo, pulse done=1 for exactly one cycle, busy=0, go to IDLE.
- Divide by zero: hi=op_a (original), lo=all ones, div_by_zero=1. done is asserted 2 cycles after the start edge.
- Latency for a normal op:
  - start sampled at edge E0; iterations on edges E1..E_WIDTH; FINISH at edge E_WIDTH+1.
  - done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after acceptance (33 for WIDTH=32).
- stall = busy | (IDLE & start & alu_ctl is ALU_MUL or ALU_DIV). The pipeline is therefore held from the start cycle through the cycle before done. stall=0 while done=1.
- Overflow case: 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. No exception is raised.
- start while busy: ignored, with no effect on the operation in flight.
- flush:
  - In RUN or FINISH: go to IDLE at the next edge, busy=0, no done pulse, hi/lo and div_by_zero keep their previous values.
  - In IDLE: suppresses acceptance of start. flush wins over a simultaneous start.
- Reset mid-operation: immediate return to reset values; no done pulse.
- hi/lo change only on the FINISH edge or on reset.

Decomposition:
- Shared package (mips_pkg):
  - ALU-control code constants (ALU_ADD 0010, ALU_SUB 0110, ALU_AND 0000, ALU_OR 0001, ALU_SLT 0111, ALU_NOR 0011, ALU_XOR 0100, ALU_MUL 1010, ALU_DIV 1111).
  - muldiv FSM state enum.
  - WIDTH default.
- One natural sub-module: muldiv_datapath. It holds the operand, accumulator and remainder registers, the shift/add/subtract step and the sign fix. muldiv_sequencer keeps the FSM, counter, handshake and stall.

Test Plan:
- MUL 7 * -3 (op_a=7, op_b=0xFFFFFFFD): stall=1 from the start cycle; done exactly 33 edges after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=0 with done.
- DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0. Then DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIV 5 / 0: done 2 edges after start; hi=5, lo=0xFFFFFFFF, div_by_zero=1. A following MUL 3*4 clears the flag, giving hi=0, lo=12.
- start with alu_ctl=0010 (add): busy and stall stay 0, no done. Then start pulsed during a running MUL: the original result is unchanged and only one done is produced.
- flush at count=10 of MUL 0x12345678*0x10: no done; previous hi/lo retained; next start accepted the cycle after.
- rst_n low at count=20 of DIV 100/7: all outputs 0 immediately (asynchronous). After release, DIV 100/7 gives lo=14, hi=2.
